rd_ptr_empty_ctrl: RTL and testbench

Parametrised read-side controller for the asynchronous FIFO, in the `rd_clk` domain. It synchronises the write-domain Gray pointer, keeps the binary and Gray read pointers, and drives the RAM read address. It produces a look-ahead registered `empty`, a fill level, an `almost_empty` flag and an underflow pulse. It supersedes the fixed 32-entry read-pointer logic and pairs with the write-side controller, which consumes `rd_gptr`.

---
 rtl/rd_ptr_empty_ctrl.sv | 98 +++++++++
 tb/tb_rd_ptr_empty_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_ptr_empty_ctrl.sv
// Read-side controller for the asynchronous FIFO: synchronises the write Gray pointer, keeps the
// binary/Gray read pointers and produces registered look-ahead empty, level and almost-empty flags.
module rd_ptr_empty_ctrl #(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AE_THRESH   = 4
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              rd_en,
    input  logic [ADDR_W:0]   wr_gptr_async,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   rd_gptr,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_level,
    output logic              underflow,
    output logic              rd_fire
);

    logic [ADDR_W:0] sync_q [SYNC_STAGES];
    logic [ADDR_W:0] wq_gptr;
    logic [ADDR_W:0] wq_bin;

    logic [ADDR_W:0] rd_bin_q;
    logic [ADDR_W:0] rd_gptr_q;
    logic [ADDR_W:0] rd_level_q;
    logic            empty_q;
    logic            almost_empty_q;
    logic            underflow_q;

    logic [ADDR_W:0] rd_bin_next;
    logic [ADDR_W:0] rd_gnext;
    logic [ADDR_W:0] level_next;
    logic            empty_next;
    logic            almost_empty_next;

    // Plain flop chain: no logic between stages so each stage can settle a metastable sample.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= wr_gptr_async;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wq_gptr = sync_q[SYNC_STAGES-1];

    // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i.
    always_comb begin
        wq_bin = '0;
        for (int i = 0; i <= int'(ADDR_W); i++) begin
            wq_bin[i] = ^(wq_gptr >> i);
        end
    end

    assign rd_fire     = rd_en & ~empty_q;
    assign rd_bin_next = rd_bin_q + {{ADDR_W{1'b0}}, rd_fire};
    assign rd_gnext    = rd_bin_next ^ (rd_bin_next >> 1);

    // Look-ahead flags use the post-read pointer so the last-entry read raises empty on its own edge.
    always_comb begin
        empty_next        = (rd_gnext == wq_gptr);
        level_next        = wq_bin - rd_bin_next;
        almost_empty_next = (32'(level_next) <= AE_THRESH);
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_bin_q       <= '0;
            rd_gptr_q      <= '0;
            rd_level_q     <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            underflow_q    <= 1'b0;
        end else begin
            rd_bin_q       <= rd_bin_next;
            rd_gptr_q      <= rd_gnext;
            rd_level_q     <= level_next;
            empty_q        <= empty_next;
            almost_empty_q <= almost_empty_next;
            underflow_q    <= rd_en & empty_q;
        end
    end

    assign rd_addr      = rd_bin_q[ADDR_W-1:0];
    assign rd_gptr      = rd_gptr_q;
    assign rd_level     = rd_level_q;
    assign empty        = empty_q;
    assign almost_empty = almost_empty_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_rd_ptr_empty_ctrl.sv
// Directed self-checking bench for rd_ptr_empty_ctrl with ADDR_W=5, SYNC_STAGES=2, AE_THRESH=4.
module tb_rd_ptr_empty_ctrl;

    logic       rd_clk;
    logic       rd_rst;
    logic       rd_en;
    logic [5:0] wr_gptr_async;
    logic [4:0] rd_addr;
    logic [5:0] rd_gptr;
    logic       empty;
    logic       almost_empty;
    logic [5:0] rd_level;
    logic       underflow;
    logic       rd_fire;

    int checks;
    int failures;
    logic [5:0] wbin;

    rd_ptr_empty_ctrl #(
        .ADDR_W      (5),
        .SYNC_STAGES (2),
        .AE_THRESH   (4)
    ) dut (
        .rd_clk        (rd_clk),
        .rd_rst        (rd_rst),
        .rd_en         (rd_en),
        .wr_gptr_async (wr_gptr_async),
        .rd_addr       (rd_addr),
        .rd_gptr       (rd_gptr),
        .empty         (empty),
        .almost_empty  (almost_empty),
        .rd_level      (rd_level),
        .underflow     (underflow),
        .rd_fire       (rd_fire)
    );

    initial begin
        rd_clk = 1'b0;
        forever #5 rd_clk = ~rd_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [5:0] bin2gray(input logic [5:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [5:0] gray2bin(input logic [5:0] g);
        logic [5:0] b;
        b[5] = g[5];
        for (int i = 4; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge rd_clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rd_rst = 1'b0; rd_en = 1'b0; wr_gptr_async = 6'd0;
        #3 rd_rst = 1'b1;
        #1;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL reset_ae: got %b want 1", almost_empty); end
        checks++; if (rd_addr !== 5'd0) begin failures++; $display("FAIL reset_addr: got %0d want 0", rd_addr); end
        checks++; if (rd_gptr !== 6'd0) begin failures++; $display("FAIL reset_gptr: got %0d want 0", rd_gptr); end
        checks++; if (rd_level !== 6'd0) begin failures++; $display("FAIL reset_level: got %0d want 0", rd_level); end
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow: got %b want 0", underflow); end
        step(2);
        rd_rst = 1'b0;
        step(4);
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL post_reset_empty: got %b want 1", empty); end
        checks++; if (rd_level !== 6'd0) begin failures++; $display("FAIL post_reset_level: got %0d want 0", rd_level); end
        wbin = 6'd0;
    endtask

    task automatic test_visibility_drain();
        wbin = 6'd3;
        wr_gptr_async = 6'b000010;
        step(2);
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL vis_early_empty: got %b want 1", empty); end
        step(1);
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL vis_empty: got %b want 0", empty); end
        checks++; if (rd_level !== 6'd3) begin failures++; $display("FAIL vis_level: got %0d want 3", rd_level); end
        checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL vis_ae: got %b want 1", almost_empty); end
        rd_en = 1'b1;
        #0;
        checks++; if (rd_fire !== 1'b1) begin failures++; $display("FAIL drain_fire: got %b want 1", rd_fire); end
        step(1);
        checks++; if (rd_addr !== 5'd1) begin failures++; $display("FAIL drain_addr1: got %0d want 1", rd_addr); end
        checks++; if (rd_level !== 6'd2) begin failures++; $display("FAIL drain_level1: got %0d want 2", rd_level); end
        step(1);
        checks++; if (rd_addr !== 5'd2) begin failures++; $display("FAIL drain_addr2: got %0d want 2", rd_addr); end
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL drain_empty2: got %b want 0", empty); end
        step(1);
        checks++; if (rd_addr !== 5'd3) begin failures++; $display("FAIL drain_addr3: got %0d want 3", rd_addr); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty3: got %b want 1", empty); end
        checks++; if (rd_level !== 6'd0) begin failures++; $display("FAIL drain_level3: got %0d want 0", rd_level); end
        checks++; if (rd_fire !== 1'b0) begin failures++; $display("FAIL drain_nofire: got %b want 0", rd_fire); end
        rd_en = 1'b0;
    endtask

    task automatic test_underflow();
        rd_en = 1'b1;
        #0;
        checks++; if (rd_fire !== 1'b0) begin failures++; $display("FAIL uf_fire: got %b want 0", rd_fire); end
        step(1);
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL uf_pulse1: got %b want 1", underflow); end
        checks++; if (rd_addr !== 5'd3) begin failures++; $display("FAIL uf_addr1: got %0d want 3", rd_addr); end
        checks++; if (rd_gptr !== 6'b000010) begin failures++; $display("FAIL uf_gptr1: got %b want 000010", rd_gptr); end
        step(1);
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL uf_pulse2: got %b want 1", underflow); end
        checks++; if (rd_addr !== 5'd3) begin failures++; $display("FAIL uf_addr2: got %0d want 3", rd_addr); end
        rd_en = 1'b0;
        step(1);
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL uf_clear: got %b want 0", underflow); end
    endtask

    task automatic test_full_level();
        rd_rst = 1'b1;
        wr_gptr_async = 6'd0;
        step(1);
        rd_rst = 1'b0;
        step(1);
        wbin = 6'd32;
        wr_gptr_async = 6'b110000;
        step(3);
        checks++; if (rd_level !== 6'd32) begin failures++; $display("FAIL full_level: got %0d want 32", rd_level); end
        checks++; if (almost_empty !== 1'b0) begin failures++; $display("FAIL full_ae: got %b want 0", almost_empty); end
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL full_empty: got %b want 0", empty); end
        rd_en = 1'b1;
        step(27);
        checks++; if (rd_level !== 6'd5) begin failures++; $display("FAIL level5: got %0d want 5", rd_level); end
        checks++; if (almost_empty !== 1'b0) begin failures++; $display("FAIL level5_ae: got %b want 0", almost_empty); end
        checks++; if (rd_addr !== 5'd27) begin failures++; $display("FAIL level5_addr: got %0d want 27", rd_addr); end
        step(1);
        rd_en = 1'b0;
        checks++; if (rd_level !== 6'd4) begin failures++; $display("FAIL level4: got %0d want 4", rd_level); end
        checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL level4_ae: got %b want 1", almost_empty); end
    endtask

    task automatic test_wrap();
        int written;
        logic [5:0] rb;
        logic [5:0] prev_g;
        logic [4:0] prev_a;
        bit seen_addr_wrap;
        bit seen_ptr_wrap;
        bit done;
        written = 0; seen_addr_wrap = 0; seen_ptr_wrap = 0; done = 0;
        rd_en = 1'b1;
        rb = gray2bin(rd_gptr);
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            if (written < 100 && (cyc % 5) != 3 && 6'(wbin - rb) < 6'd32) begin
                wbin = wbin + 6'd1;
                wr_gptr_async = bin2gray(wbin);
                written++;
            end
            prev_g = rd_gptr;
            prev_a = rd_addr;
            step(1);
            rb = gray2bin(rd_gptr);
            checks++;
            if ($countones(prev_g ^ rd_gptr) > 1) begin
                failures++; $display("FAIL wrap_gray_step: got %b after %b", rd_gptr, prev_g);
            end
            checks++;
            if (6'(wbin - rb) > 6'd32) begin
                failures++; $display("FAIL wrap_overread: read ptr %0d write ptr %0d", rb, wbin);
            end
            checks++;
            if (rd_level > 6'd32) begin
                failures++; $display("FAIL wrap_level_range: got %0d want <=32", rd_level);
            end
            if (prev_a == 5'd31 && rd_addr == 5'd0) seen_addr_wrap = 1;
            if (prev_g == 6'b100000 && rd_gptr == 6'd0) seen_ptr_wrap = 1;
            if (written == 100 && rb == wbin) done = 1;
        end
        rd_en = 1'b0;
        checks++; if (!done) begin failures++; $display("FAIL wrap_drain_timeout: read %0d written %0d", rb, wbin); end
        checks++; if (!seen_addr_wrap) begin failures++; $display("FAIL wrap_addr: got no 31->0 want wrap"); end
        checks++; if (!seen_ptr_wrap) begin failures++; $display("FAIL wrap_ptr: got no 63->0 want wrap"); end
        checks++; if (rd_addr !== 5'd4) begin failures++; $display("FAIL wrap_final_addr: got %0d want 4", rd_addr); end
        checks++; if (rd_gptr !== 6'b000110) begin failures++; $display("FAIL wrap_final_gptr: got %b want 000110", rd_gptr); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_final_empty: got %b want 1", empty); end
        checks++; if (rd_level !== 6'd0) begin failures++; $display("FAIL wrap_final_level: got %0d want 0", rd_level); end
    endtask

    task automatic test_simultaneous();
        // Write pointer at 4 here; move to 5 to reach level 1.
        wbin = 6'd5;
        wr_gptr_async = 6'b000111;
        step(3);
        checks++; if (rd_level !== 6'd1) begin failures++; $display("FAIL sim_pre_level: got %0d want 1", rd_level); end
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL sim_pre_empty: got %b want 0", empty); end
        wbin = 6'd6;
        wr_gptr_async = 6'b000101;
        step(2);
        checks++; if (rd_level !== 6'd1) begin failures++; $display("FAIL sim_mid_level: got %0d want 1", rd_level); end
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL sim_empty: got %b want 0", empty); end
        checks++; if (rd_level !== 6'd1) begin failures++; $display("FAIL sim_level: got %0d want 1", rd_level); end
        checks++; if (rd_addr !== 5'd5) begin failures++; $display("FAIL sim_addr: got %0d want 5", rd_addr); end
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL sim_last_empty: got %b want 1", empty); end
        checks++; if (rd_addr !== 5'd6) begin failures++; $display("FAIL sim_last_addr: got %0d want 6", rd_addr); end
    endtask

    task automatic test_reset_mid();
        wbin = 6'd10;
        wr_gptr_async = 6'b001111;
        step(3);
        checks++; if (rd_level !== 6'd4) begin failures++; $display("FAIL mid_pre_level: got %0d want 4", rd_level); end
        rd_en = 1'b1;
        step(1);
        checks++; if (rd_addr !== 5'd7) begin failures++; $display("FAIL mid_pre_addr: got %0d want 7", rd_addr); end
        #2 rd_rst = 1'b1;
        #1;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL mid_rst_empty: got %b want 1", empty); end
        checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL mid_rst_ae: got %b want 1", almost_empty); end
        checks++; if (rd_addr !== 5'd0) begin failures++; $display("FAIL mid_rst_addr: got %0d want 0", rd_addr); end
        checks++; if (rd_gptr !== 6'd0) begin failures++; $display("FAIL mid_rst_gptr: got %0d want 0", rd_gptr); end
        checks++; if (rd_level !== 6'd0) begin failures++; $display("FAIL mid_rst_level: got %0d want 0", rd_level); end
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL mid_rst_underflow: got %b want 0", underflow); end
        checks++; if (rd_fire !== 1'b0) begin failures++; $display("FAIL mid_rst_fire: got %b want 0", rd_fire); end
        wr_gptr_async = 6'd0;
        wbin = 6'd0;
        rd_en = 1'b0;
        step(2);
        rd_rst = 1'b0;
        step(4);
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL mid_post_empty: got %b want 1", empty); end
        checks++; if (rd_level !== 6'd0) begin failures++; $display("FAIL mid_post_level: got %0d want 0", rd_level); end
        checks++; if (rd_addr !== 5'd0) begin failures++; $display("FAIL mid_post_addr: got %0d want 0", rd_addr); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_visibility_drain();
        test_underflow();
        test_full_level();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
